// File: rtl/dram_master_pkg.sv
// Shared state encoding, request layout and default widths for the DRAM port master.
package dram_master_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_CAP,
    RMW_RD,
    RMW_CAP,
    RMW_WR
  } state_e;

  typedef struct packed {
    logic                    we;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
    logic [DATA_W_DEF/8-1:0] be;
  } req_t;

endpackage

// File: rtl/dram_req_fifo.sv
// Synchronous request FIFO; push while full is honoured only when a pop happens in the same cycle.
module dram_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by plain overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  assign dout = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dram_port_master.sv
// Initiator for a single-port RAM bus (Addr/Data/CS/R_W): buffers requests, sequences cycles, owns Data.
// Optional DRAM_MASTER_BYTE_WRITE_EN adds req_be with read-modify-write for partial byte masks.
module dram_port_master
  import dram_master_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DRAM_MASTER_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] Addr,
  inout  wire  [DATA_W-1:0] Data,
  output logic              CS,
  output logic              R_W
);

  localparam int BE_W = DATA_W / 8;
`ifdef DRAM_MASTER_BYTE_WRITE_EN
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W + BE_W;
`else
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                cs_q, cs_d, rw_q, rw_d, drive_q, drive_d;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_din, fifo_dout;
  logic                head_we, head_full_word;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;

`ifdef DRAM_MASTER_BYTE_WRITE_EN
  logic [BE_W-1:0]     be_q, be_d, head_be;

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] wd,
                                                   input logic [DATA_W-1:0] rd,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] m;
    m = rd;
    for (int i = 0; i < BE_W; i++) m[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : rd[i*8 +: 8];
    return m;
  endfunction

  assign fifo_din       = {req_we, req_addr, req_wdata, req_be};
  assign head_wdata     = fifo_dout[BE_W +: DATA_W];
  assign head_be        = fifo_dout[BE_W-1:0];
  assign head_full_word = (head_be == '1);
`else
  assign fifo_din       = {req_we, req_addr, req_wdata};
  assign head_wdata     = fifo_dout[DATA_W-1:0];
  assign head_full_word = 1'b1;
`endif
  assign head_we   = fifo_dout[ENTRY_W-1];
  assign head_addr = fifo_dout[ENTRY_W-2 -: ADDR_W];

  assign req_ready = !fifo_full && !RST;
  assign fifo_push = req_valid && req_ready;

  dram_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 1'b0;
    fifo_pop    = 1'b0;
`ifdef DRAM_MASTER_BYTE_WRITE_EN
    be_d        = be_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          if (head_we) begin
            wdata_d = head_wdata;
            state_d = WR;
`ifdef DRAM_MASTER_BYTE_WRITE_EN
            be_d = head_be;
            if (head_be == '0)     state_d = IDLE;
            else if (!head_full_word) state_d = RMW_RD;
`endif
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        // Back-to-back full-word writes stream at one per cycle.
        if (!fifo_empty && head_we && head_full_word) begin
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          wdata_d  = head_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      RD:     state_d = RD_CAP;
      RD_CAP: begin
        rsp_rdata_d = Data;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
`ifdef DRAM_MASTER_BYTE_WRITE_EN
      RMW_RD:  state_d = RMW_CAP;
      RMW_CAP: begin
        wdata_d = byte_merge(wdata_q, Data, be_q);
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    // Bus controls are registered copies of the next state, so they line up with state_q.
    cs_d    = (state_d != IDLE);
    rw_d    = !((state_d == WR) || (state_d == RMW_WR));
    drive_d = !rw_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      rw_q        <= 1'b1;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      rw_q        <= rw_d;
      drive_q     <= drive_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    wdata_q <= wdata_d;
`ifdef DRAM_MASTER_BYTE_WRITE_EN
    be_q    <= be_d;
`endif
  end

  assign Data      = drive_q ? wdata_q : 'z;
  assign Addr      = addr_q;
  assign CS        = cs_q;
  assign R_W       = rw_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dram_port_master.sv
// Scoreboard bench for dram_port_master with a behavioural synchronous RAM on the bus.
module tb_dram_port_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid, req_we;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, busy, CS, R_W;
  logic [31:0] rsp_rdata;
  logic [11:0] Addr;
  wire  [31:0] Data;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int run_len = 0;
  int max_run = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] mon_e;
  int          mon_l;

  dram_port_master dut (
    .CLK      (CLK),
    .RST      (RST),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
`ifdef DRAM_MASTER_BYTE_WRITE_EN
    .req_be   (req_be),
`endif
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .Addr     (Addr),
    .Data     (Data),
    .CS       (CS),
    .R_W      (R_W)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM: commits writes at the edge ending a write cycle; registers reads, drives while CS&&R_W held.
  logic [31:0] mem [4096];
  logic [31:0] rd_q;
  logic        rd_vld_q;
  logic        mem_drv;
  assign mem_drv = rd_vld_q && CS && R_W;
  assign Data    = mem_drv ? rd_q : 'z;
  always @(posedge CLK) begin
    if (CS && !R_W) mem[Addr] <= Data;
    rd_vld_q <= CS && R_W;
    rd_q     <= mem[Addr];
  end

  // Response monitor and bus protocol check.
  always @(negedge CLK) begin
    if (rsp_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: rsp_valid with rdata %h, no response expected", rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = lat_q.pop_front();
        if (rsp_rdata !== mon_e) begin
          fails++;
          $display("FAIL rsp_rdata: got %h, expected %h", rsp_rdata, mon_e);
        end
        if (mon_l >= 0) begin
          vectors++;
          if (cyc != mon_l) begin
            fails++;
            $display("FAIL rsp_latency: rsp_valid at cycle %0d, expected cycle %0d", cyc, mon_l);
          end
        end
      end
    end
    if (!RST) begin
      vectors++;
      if (!R_W && !CS) begin
        fails++;
        $display("FAIL bus_protocol: R_W=0 with CS=0 at cycle %0d", cyc);
      end
    end
    if (CS && !R_W) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic we, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit expect_rsp, input bit chk_lat);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    while (!req_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (!req_ready) begin
      fails++;
      $display("FAIL accept_timeout: req_ready %0b after %0d cycles, expected 1", req_ready, n);
    end else begin
      if (!we && expect_rsp) begin
        exp_q.push_back(d);
        lat_q.push_back(chk_lat ? cyc + 4 : -1);
      end
      @(negedge CLK);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 300) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (busy) begin
      fails++;
      $display("FAIL idle_timeout: busy %0b after %0d cycles, expected 0", busy, n);
    end
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_cs"},        32'(CS), 32'd0);
    check({tag, "_rw"},        32'(R_W), 32'd1);
    check({tag, "_addr"},      32'(Addr), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = 4'hF;
    repeat (3) @(negedge CLK);
    check_reset_state("init");
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Back-to-back writes: CS rises the cycle after the first acceptance.
    send(1'b1, 12'd0, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    check("wr_T0_cs", 32'(CS), 32'd0);
    send(1'b1, 12'd1, 32'hBAADF00D, 4'hF, 1'b0, 1'b0);
    check("wr0_cs", 32'(CS), 32'd1);
    check("wr0_rw", 32'(R_W), 32'd0);
    check("wr0_addr", 32'(Addr), 32'd0);
    send(1'b1, 12'd2, 32'hCCCCCCCC, 4'hF, 1'b0, 1'b0);
    check("wr1_cs", 32'(CS), 32'd1);
    check("wr1_rw", 32'(R_W), 32'd0);
    check("wr1_addr", 32'(Addr), 32'd1);
    @(negedge CLK);
    check("wr2_rw", 32'(R_W), 32'd0);
    check("wr2_addr", 32'(Addr), 32'd2);
    @(negedge CLK);
    check("wr_done_cs", 32'(CS), 32'd0);
    wait_idle();
    send(1'b0, 12'd0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    wait_idle();
    send(1'b0, 12'd1, 32'hBAADF00D, 4'hF, 1'b1, 1'b1);
    wait_idle();

    // Backpressure: third read fills the FIFO while the first is on the bus.
    send(1'b0, 12'd0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    send(1'b0, 12'd1, 32'hBAADF00D, 4'hF, 1'b1, 1'b0);
    send(1'b0, 12'd2, 32'hCCCCCCCC, 4'hF, 1'b1, 1'b0);
    check("bp_full", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("bp_still_full", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("bp_release", 32'(req_ready), 32'd1);
    wait_idle();

    // Read then write to the same address: a CS=0 cycle must separate them.
    send(1'b0, 12'd2, 32'hCCCCCCCC, 4'hF, 1'b1, 1'b0);
    send(1'b1, 12'd2, 32'h22222222, 4'hF, 1'b0, 1'b0);
    @(negedge CLK);
    check("ta_rdcap_cs", 32'(CS), 32'd1);
    check("ta_rdcap_rw", 32'(R_W), 32'd1);
    @(negedge CLK);
    check("ta_gap_cs", 32'(CS), 32'd0);
    @(negedge CLK);
    check("ta_wr_cs", 32'(CS), 32'd1);
    check("ta_wr_rw", 32'(R_W), 32'd0);
    wait_idle();
    send(1'b0, 12'd2, 32'h22222222, 4'hF, 1'b1, 1'b1);
    wait_idle();

    // Reset during RD_CAP drops the in-flight and the queued read.
    send(1'b0, 12'd0, 32'h0, 4'hF, 1'b0, 1'b0);
    send(1'b0, 12'd1, 32'h0, 4'hF, 1'b0, 1'b0);
    @(negedge CLK);
    check("mid_rdcap_cs", 32'(CS), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_state("mid");
    RST = 1'b0;
    @(negedge CLK);
    check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    send(1'b0, 12'd0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    wait_idle();

`ifdef DRAM_MASTER_BYTE_WRITE_EN
    send(1'b1, 12'd0, 32'h12345678, 4'b0011, 1'b0, 1'b0);
    wait_idle();
    send(1'b0, 12'd0, 32'hDEAD5678, 4'hF, 1'b1, 1'b0);
    wait_idle();
    send(1'b1, 12'd0, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("be0_no_cs", 32'(CS), 32'd0);
      @(negedge CLK);
    end
    wait_idle();
    send(1'b0, 12'd0, 32'hDEAD5678, 4'hF, 1'b1, 1'b0);
    wait_idle();
`endif

    // Sweep: 20 writes stream one per cycle, then read back.
    for (int i = 0; i < 20; i++) send(1'b1, 12'(i), 32'(i), 4'hF, 1'b0, 1'b0);
    wait_idle();
    check("sweep_wr_run", 32'(max_run), 32'd20);
    for (int i = 0; i < 20; i++) send(1'b0, 12'(i), 32'(i), 4'hF, 1'b1, 1'b0);
    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/dram_port_master.md
Name: dram_port_master

Overview:
- Initiator side of the single-port DRAM/RAM interface: Addr, inout Data, CS, R_W.
- Accepts word read/write requests from the CPU or load/store side over a valid/ready handshake.
- Buffers requests in a 2-entry FIFO and sequences CS/R_W/Addr/Data cycles. Owns the tristate on Data.
- Returns read data as a one-cycle response pulse. One transaction is outstanding on the memory port; completion is in order.

Parameters:
- ADDR_W, 12, memory address width (4K words).
- DATA_W, 32, data word width.
- FIFO_DEPTH, 2, request buffer entries (power of 2, minimum 2).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full; request accepted on req_valid && req_ready at the posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  DATA_W  read data; held until the next rsp_valid.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- Addr  out  ADDR_W  memory address (registered).
- Data  inout  DATA_W  memory data bus; driven only during write cycles, Z otherwise.
- CS  out  1  memory chip select (registered).
- R_W  out  1  1 = read, 0 = write (registered).

Behaviour:
- Reset (RST high at posedge):
  - CS=0, R_W=1, Addr=0, Data released (Z), rsp_valid=0, rsp_rdata=0, busy=0.
  - FIFO emptied; FSM to IDLE.
  - req_ready=0 while RST is high and 1 from the first cycle after.
- Reset mid-operation: the in-flight and buffered requests are dropped; no response is issued. A write whose cycle was interrupted has an undefined memory effect.
- FSM states: IDLE, WR, RD, RD_CAP (plus RMW_RD, RMW_CAP, RMW_WR under the optional feature).
- IDLE:
  - CS=0, R_W=1.
  - If the FIFO is non-empty: pop; load Addr (and the write-data register for writes); go to WR (req_we=1) or RD.
- WR:
  - CS=1, R_W=0; Data driven with the write register for exactly one cycle. Memory commits at the posedge ending WR.
  - Next state: if the FIFO is non-empty and the head is a write, pop and stay in WR (back-to-back writes, one per cycle). Otherwise go to IDLE.
- RD:
  - CS=1, R_W=1, Data Z for one cycle. Memory registers the read at the posedge ending RD.
  - Next state: RD_CAP.
- RD_CAP:
  - CS=1, R_W=1 held so memory keeps driving.
  - Data sampled into rsp_rdata at the posedge ending RD_CAP; rsp_valid=1 for the following cycle.
  - Next state: IDLE unconditionally. This gives at least one CS=0, R_W=1 turnaround cycle before any later write drives Data.
- Latency, with acceptance at edge T0:
  - Write: CS asserted during cycle T1 (FSM pops at T1).
  - Read: rsp_valid high during cycle T3–T4.
- Throughput:
  - Writes: 1 per cycle sustained.
  - Reads: 1 per 3 cycles.
  - Read followed by write: 1 idle cycle between.
- FIFO:
  - Push and pop in the same cycle when full is allowed; count stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Never at any posedge: R_W=0 with CS=0 while Data is driven. Data is never driven while R_W=1.

Optional Feature:
- Macro: DRAM_MASTER_BYTE_WRITE_EN.
- With the macro:
  - Adds port req_be in 4 (DATA_W/8), stored in the FIFO alongside each request.
  - req_be=4'hF: plain write.
  - req_be=4'h0: write dropped with no bus cycle.
  - Partial mask: read-modify-write sequence RMW_RD → RMW_CAP → RMW_WR. RMW_RD and RMW_CAP behave as RD and RD_CAP but produce no rsp_valid.
  - In RMW_WR: merged = (be[i] ? wdata byte i : read byte i). Written with CS=1, R_W=0; then IDLE.
  - Cost: 3 bus cycles plus 1 turnaround.
- Without the macro: no req_be port; every write is a full word.

Decomposition:
- Package dram_master_pkg holds:
  - state enum (IDLE, WR, RD, RD_CAP, RMW_RD, RMW_CAP, RMW_WR);
  - request struct (we, addr, wdata, be);
  - width constants ADDR_W_DEF=12, DATA_W_DEF=32.
- Sub-module dram_req_fifo: synchronous FIFO, push/pop/full/empty, parameterised width and depth.
- Top level: FSM, output registers, tristate assign, byte merge.

Test Plan:
- Writes then reads: write 0xDEADBEEF to addr 0 and 0xBAADF00D to addr 1 back-to-back. Memory sees two consecutive WR cycles. Reading addr 0 then addr 1 gives rsp_rdata 0xDEADBEEF, then 0xBAADF00D, each rsp_valid 3 cycles after acceptance.
- Backpressure: hold req_valid with 3 reads queued while the first is in RD. req_ready drops to 0 when 2 entries are held, and rises after the pop. All 3 responses arrive in order.
- Turnaround: read addr 2 (holding 0xCCCCCCCC), then write 0x22222222 to addr 2. At least one CS=0 cycle separates RD_CAP and WR, and a bus contention monitor never flags X on Data. A re-read returns 0x22222222.
- Reset mid-read: assert RST during RD_CAP. No rsp_valid; outputs go to reset values the next cycle; FIFO empty. A subsequent read of addr 0 returns 0xDEADBEEF.
- Write sweep: fill addresses 0..19 with data = address at 1 write per cycle. A read sweep returns 0..19. Confirm Data is Z on every non-WR cycle.
- DRAM_MASTER_BYTE_WRITE_EN: addr 0 = 0xDEADBEEF. Write wdata 0x12345678 with be=4'b0011. A read returns 0xDEAD5678. be=4'h0 leaves 0xDEAD5678 with no CS pulse.
